// File: rtl/qspi_target.sv
// QPI-mode memory responder: quad read/write transactions into an internal byte array,
// plus a backdoor host port for preload and inspection.
module qspi_target #(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned DUMMY     = 6,
  parameter logic [7:0]  CMD_READ  = 8'hEB,
  parameter logic [7:0]  CMD_WRITE = 8'h38
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cs_n,
  input  logic                         sclk,
  input  logic [3:0]                   sd_in,
  output logic [3:0]                   sd_out,
  output logic [3:0]                   sd_oe,
  input  logic [$clog2(MEM_BYTES)-1:0] bd_addr,
  input  logic                         bd_we,
  input  logic [7:0]                   bd_wdata,
  output logic [7:0]                   bd_rdata
);
  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  state_t          state_q, state_d;
  logic            sclk_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [23:0]     sh_q, sh_d, sh_nx;
  logic [AW-1:0]   addr_q, addr_d;
  logic            ph_q, ph_d;
  logic [3:0]      hi_q, hi_d;
  logic            rd_q, rd_d;
  logic [3:0]      sd_out_d, sd_oe_d;
  logic            mem_we;
  logic [7:0]      mem_wdata;
  logic [7:0]      rd_byte;
  logic            rise, fall;
  logic [7:0]      mem [MEM_BYTES];

  assign rise    = sclk & ~sclk_q;
  assign fall    = ~sclk & sclk_q;
  assign sh_nx   = {sh_q[19:0], sd_in};
  // Asynchronous fetch: the byte under addr is always ready well before the presenting Fall.
  assign rd_byte = mem[addr_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    ph_d      = ph_q;
    hi_d      = hi_q;
    rd_d      = rd_q;
    sd_out_d  = sd_out;
    sd_oe_d   = sd_oe;
    mem_we    = 1'b0;
    mem_wdata = {hi_q, sd_in};
    if (cs_n) begin
      state_d  = S_IDLE;
      sd_oe_d  = 4'h0;
      sd_out_d = 4'h0;
      cnt_d    = '0;
      ph_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          cnt_d   = '0;
          sh_d    = '0;
          ph_d    = 1'b0;
        end
        S_CMD: if (rise) begin
          sh_d  = sh_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(1)) begin
            cnt_d = '0;
            if (sh_nx[7:0] == CMD_READ) begin
              state_d = S_ADDR;
              rd_d    = 1'b1;
            end else if (sh_nx[7:0] == CMD_WRITE) begin
              state_d = S_ADDR;
              rd_d    = 1'b0;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR: if (rise) begin
          sh_d  = sh_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(5)) begin
            cnt_d  = '0;
            addr_d = sh_nx[AW-1:0];
            if (!rd_q)           state_d = S_WDATA;
            else if (DUMMY == 0) state_d = S_RDATA;
            else                 state_d = S_DUMMY;
          end
        end
        S_DUMMY: if (rise) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DUMMY - 1)) begin
            cnt_d   = '0;
            state_d = S_RDATA;
          end
        end
        S_RDATA: if (fall) begin
          sd_oe_d = 4'hF;
          ph_d    = ~ph_q;
          if (!ph_q) begin
            sd_out_d = rd_byte[7:4];
          end else begin
            sd_out_d = rd_byte[3:0];
            addr_d   = addr_q + AW'(1);
          end
        end
        S_WDATA: if (rise) begin
          ph_d = ~ph_q;
          if (!ph_q) begin
            hi_d = sd_in;
          end else begin
            mem_we = 1'b1;
            addr_d = addr_q + AW'(1);
          end
        end
        default: sd_oe_d = 4'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sclk_q   <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
      addr_q   <= '0;
      ph_q     <= 1'b0;
      hi_q     <= 4'h0;
      rd_q     <= 1'b0;
      sd_out   <= 4'h0;
      sd_oe    <= 4'h0;
      bd_rdata <= 8'h00;
    end else begin
      state_q  <= state_d;
      sclk_q   <= sclk;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      addr_q   <= addr_d;
      ph_q     <= ph_d;
      hi_q     <= hi_d;
      rd_q     <= rd_d;
      sd_out   <= sd_out_d;
      sd_oe    <= sd_oe_d;
      bd_rdata <= mem[bd_addr];
    end
  end

  // QSPI write is issued last so it wins over a same-clk backdoor write to its address.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (mem_we && !reset) mem[addr_q] <= mem_wdata;
  end

endmodule

// File: tb/tb_qspi_target.sv
// Randomized bench for qspi_target: acts as the QSPI controller and checks against a byte-array model.
module tb_qspi_target;
  localparam int DUMMY = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b0;
  logic [3:0] sd_in = 4'h0;
  logic [3:0] sd_out, sd_oe;
  logic [7:0] bd_addr = 8'h00;
  logic       bd_we = 1'b0;
  logic [7:0] bd_wdata = 8'h00;
  logic [7:0] bd_rdata;

  qspi_target #(.MEM_BYTES(256), .DUMMY(DUMMY), .CMD_READ(8'hEB), .CMD_WRITE(8'h38)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sclk(sclk), .sd_in(sd_in),
    .sd_out(sd_out), .sd_oe(sd_oe), .bd_addr(bd_addr), .bd_we(bd_we),
    .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
  );

  always #5 clk = ~clk;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic       settled = 1'b0;
  logic       out_chk = 1'b0;
  logic [3:0] oe_exp = 4'h0;
  logic [3:0] out_exp = 4'h0;
  logic [7:0] model [256];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    else pass_cnt++;
  endtask

  // Pin-level compare against the expectation the controller side has published.
  always @(negedge clk) begin
    if (settled) begin
      chk("sd_oe", {4'h0, sd_oe}, {4'h0, oe_exp});
      if (oe_exp == 4'hF || out_chk) chk("sd_out", {4'h0, sd_out}, {4'h0, out_exp});
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic sclk_phase(input logic lvl, input logic [3:0] oe, input logic [3:0] o);
    settled = 1'b0;
    oe_exp  = oe;
    out_exp = o;
    sclk    = lvl;
    @(posedge clk); #1;
    settled = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic set_cs(input logic v);
    settled = 1'b0;
    cs_n    = v;
    @(posedge clk); #1;
    oe_exp  = 4'h0;
    settled = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_nib(input logic [3:0] n);
    sd_in = n;
    sclk_phase(1'b0, 4'h0, 4'h0);
    sclk_phase(1'b1, 4'h0, 4'h0);
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
    set_cs(1'b0);
    send_nib(cmd[7:4]);
    send_nib(cmd[3:0]);
    for (int i = 5; i >= 0; i--) send_nib(a[4*i +: 4]);
  endtask

  task automatic dummies();
    for (int i = 0; i < DUMMY; i++) send_nib(4'($urandom));
  endtask

  task automatic wr(input logic [23:0] a, input int nnib, input logic [31:0] data);
    hdr(8'h38, a);
    for (int k = 0; k < nnib; k++) send_nib(data[31-4*k -: 4]);
    set_cs(1'b1);
    for (int k = 0; k < nnib / 2; k++) model[8'(a[7:0] + 8'(k))] = data[31-8*k -: 8];
  endtask

  task automatic rd(input logic [23:0] a, input int nbytes);
    logic [7:0] p, b;
    p = a[7:0];
    hdr(8'hEB, a);
    dummies();
    for (int k = 0; k < nbytes; k++) begin
      b = model[p];
      sd_in = 4'($urandom);
      sclk_phase(1'b0, 4'hF, b[7:4]);
      sclk_phase(1'b1, 4'hF, b[7:4]);
      sclk_phase(1'b0, 4'hF, b[3:0]);
      sclk_phase(1'b1, 4'hF, b[3:0]);
      p = p + 8'd1;
    end
    set_cs(1'b1);
  endtask

  task automatic bd_wr(input logic [7:0] a, input logic [7:0] d, input bit chk_old);
    bd_addr  = a;
    bd_wdata = d;
    bd_we    = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    if (chk_old) chk("bd_collide_old", bd_rdata, model[a]);
    model[a] = d;
  endtask

  task automatic bd_rd(input logic [7:0] a, input logic [7:0] exp);
    bd_addr = a;
    @(posedge clk); #1;
    chk("bd_rdata", bd_rdata, exp);
  endtask

  initial begin
    logic [7:0]  a8;
    logic [23:0] ra;
    int          n;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_bd_rdata", bd_rdata, 8'h00);
    reset = 1'b0;

    // cs_n high with sclk toggling: target stays silent
    out_chk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sd_in = 4'($urandom);
      sclk_phase(1'b1, 4'h0, 4'h0);
      sclk_phase(1'b0, 4'h0, 4'h0);
    end
    out_chk = 1'b0;

    bd_wr(8'h10, 8'h11, 1'b0);
    bd_rd(8'h10, 8'h11);

    for (int i = 0; i < 256; i++) bd_wr(8'(i), 8'($urandom), 1'b0);

    wr(24'h000010, 4, 32'hA53C_0000);
    bd_rd(8'h10, 8'hA5);
    bd_rd(8'h11, 8'h3C);
    rd(24'h000010, 2);

    wr(24'h0000FF, 4, 32'h1234_0000);
    bd_rd(8'hFF, 8'h12);
    bd_rd(8'h00, 8'h34);
    rd(24'h0000FF, 2);

    // half a byte, then deselect: nothing is written
    wr(24'h000020, 1, 32'h7000_0000);
    bd_rd(8'h20, model[8'h20]);

    // unknown command followed by traffic
    hdr(8'h9F, 24'($urandom));
    for (int i = 0; i < 10; i++) send_nib(4'($urandom));
    set_cs(1'b1);

    // reset in the middle of read data
    hdr(8'hEB, 24'h000010);
    dummies();
    sclk_phase(1'b0, 4'hF, 4'hA);
    sclk_phase(1'b1, 4'hF, 4'hA);
    settled = 1'b0;
    reset   = 1'b1;
    @(posedge clk); #1;
    oe_exp  = 4'h0;
    out_exp = 4'h0;
    out_chk = 1'b1;
    settled = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_chk = 1'b0;
    rd(24'h000010, 1);

    for (int it = 0; it < 8; it++) begin
      ra = 24'($urandom);
      if (it == 0) ra[7:0] = 8'hFE;
      n = int'($urandom_range(1, 4));
      wr(ra, 2 * n, $urandom);
      rd(ra, n);
    end

    for (int i = 0; i < 4; i++) begin
      a8 = 8'($urandom);
      bd_wr(a8, 8'($urandom), 1'b1);
      bd_rd(a8, model[a8]);
    end

    for (int i = 0; i < 256; i++) bd_rd(8'(i), model[i]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
